mc_ctrl_p: RTL and testbench

Parametrised multicycle MIPS control unit: Moore/Mealy FSM driving the datapath enables, muxes and ALU opcode of the multicycle core, one instruction at a time. It adds three things to the base controller:
- a memory-ready handshake with a bounded wait,
- illegal-instruction and bus-timeout trapping into a sticky TRAP state,
- a parametrised ALU opcode width.

It sits between the instruction register decode fields and the multicycle datapath/memory port.

---
 rtl/mc_ctrl_p.sv | 233 +++++++++++++++++++++++
 tb/tb_mc_ctrl_p.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_p.sv
// mc_ctrl_p: multicycle MIPS control FSM with memory wait, timeout and traps.
// Define SUBWORD_EN to decode lb/lbu/lh/lhu/sb/sh (otherwise they trap).
module mc_ctrl_p #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Zero,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               EXTOp,
    output logic               ALUSrcA,
    output logic               AregSel,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               IorD,
    output logic [1:0]         MemSize,
    output logic               LdUnsigned,
    output logic               IllegalInstr,
    output logic               BusErr,
    output logic [2:0]         State
);
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
    localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3;
    localparam logic [3:0] A_OR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6;
    localparam logic [3:0] A_SLL = 4'd7, A_SRL = 4'd8, A_NOR = 4'd9;
    localparam logic [3:0] A_LUI = 4'd10, A_XOR = 4'd11, A_SRA = 4'd12;
    localparam bit TO_EN = MEM_TIMEOUT > 0;
    localparam int CW = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = TO_EN ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic          waiting, timeout;
    logic [3:0]    alu_op;

    logic d_legal, d_rtype, d_shamt, d_imm, d_zext, d_load, d_store;
    logic d_beq, d_bne, d_j, d_jal, d_jr, d_jalr;
    logic [3:0] d_alu;
`ifdef SUBWORD_EN
    logic [1:0] d_size;
    logic       d_uns;
`endif

    // instruction decode from the IR opcode/function fields
    always_comb begin
        d_legal = 1'b1; d_rtype = 1'b0; d_shamt = 1'b0;
        d_imm = 1'b0; d_zext = 1'b0; d_load = 1'b0; d_store = 1'b0;
        d_beq = 1'b0; d_bne = 1'b0; d_j = 1'b0; d_jal = 1'b0;
        d_jr = 1'b0; d_jalr = 1'b0; d_alu = A_ADD;
`ifdef SUBWORD_EN
        d_size = 2'd0; d_uns = 1'b0;
`endif
        case (Op)
            6'h00: begin
                d_rtype = 1'b1;
                case (Funct)
                    6'h20, 6'h21: d_alu = A_ADD;
                    6'h22, 6'h23: d_alu = A_SUB;
                    6'h24: d_alu = A_AND;
                    6'h25: d_alu = A_OR;
                    6'h26: d_alu = A_XOR;
                    6'h27: d_alu = A_NOR;
                    6'h2A: d_alu = A_SLT;
                    6'h2B: d_alu = A_SLTU;
                    6'h00: begin d_alu = A_SLL; d_shamt = 1'b1; end
                    6'h02: begin d_alu = A_SRL; d_shamt = 1'b1; end
                    6'h03: begin d_alu = A_SRA; d_shamt = 1'b1; end
                    6'h04: d_alu = A_SLL;
                    6'h06: d_alu = A_SRL;
                    6'h07: d_alu = A_SRA;
                    6'h08: d_jr = 1'b1;
                    6'h09: d_jalr = 1'b1;
                    default: d_legal = 1'b0;
                endcase
            end
            6'h02: d_j = 1'b1;
            6'h03: d_jal = 1'b1;
            6'h04: begin d_beq = 1'b1; d_alu = A_SUB; end
            6'h05: begin d_bne = 1'b1; d_alu = A_SUB; end
            6'h08: d_imm = 1'b1;
            6'h0A: begin d_imm = 1'b1; d_alu = A_SLT; end
            6'h0C: begin d_imm = 1'b1; d_zext = 1'b1; d_alu = A_AND; end
            6'h0D: begin d_imm = 1'b1; d_zext = 1'b1; d_alu = A_OR; end
            6'h0F: begin d_imm = 1'b1; d_alu = A_LUI; end
            6'h23: d_load = 1'b1;
            6'h2B: d_store = 1'b1;
`ifdef SUBWORD_EN
            6'h20: begin d_load = 1'b1; d_size = 2'd2; end
            6'h24: begin d_load = 1'b1; d_size = 2'd2; d_uns = 1'b1; end
            6'h21: begin d_load = 1'b1; d_size = 2'd1; end
            6'h25: begin d_load = 1'b1; d_size = 2'd1; d_uns = 1'b1; end
            6'h28: begin d_store = 1'b1; d_size = 2'd2; end
            6'h29: begin d_store = 1'b1; d_size = 2'd1; end
`endif
            default: d_legal = 1'b0;
        endcase
    end

    assign waiting = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout = TO_EN && waiting && !MemReady && (cnt_q == TO_LAST);

    // state, wait counter and sticky trap causes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // next state; counter runs only while stalled on memory
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        cnt_d     = '0;
        if (TO_EN && waiting && !MemReady && !timeout) cnt_d = cnt_q + CW'(1);
        case (state_q)
            S_IF: begin
                if (MemReady) state_d = S_ID;
                else if (timeout) begin
                    state_d = S_TRAP; bus_err_d = 1'b1;
                end
            end
            S_ID: begin
                if (!d_legal) begin
                    state_d = S_TRAP; illegal_d = 1'b1;
                end else if (d_j || d_jal) state_d = S_IF;
                else state_d = S_EXE;
            end
            S_EXE: begin
                if (d_beq || d_bne || d_jr || d_jalr) state_d = S_IF;
                else if (d_load || d_store) state_d = S_MEM;
                else state_d = S_WB;
            end
            S_MEM: begin
                if (MemReady) state_d = d_load ? S_WB : S_IF;
                else if (timeout) begin
                    state_d = S_TRAP; bus_err_d = 1'b1;
                end
            end
            S_WB:   state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // datapath controls for the current state; writes masked in reset
    always_comb begin
        RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        PCWrite = 1'b0; IRWrite = 1'b0; EXTOp = 1'b1;
        ALUSrcA = 1'b1; AregSel = 1'b0; ALUSrcB = 2'd0;
        alu_op = A_ADD; PCSource = 2'd0; GPRSel = 2'd0;
        WDSel = 2'd0; IorD = 1'b0; MemSize = 2'd0; LdUnsigned = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1; ALUSrcA = 1'b0; ALUSrcB = 2'd1;
                PCWrite = MemReady; IRWrite = MemReady;
            end
            S_ID: begin
                if (d_legal) begin
                    if (d_j || d_jal) begin
                        PCSource = 2'd2; PCWrite = 1'b1;
                        if (d_jal) begin
                            RegWrite = 1'b1; GPRSel = 2'd2; WDSel = 2'd2;
                        end
                    end else if (d_jalr) begin
                        RegWrite = 1'b1; WDSel = 2'd2;
                    end else if (!d_jr) begin
                        ALUSrcA = 1'b0; ALUSrcB = 2'd3;
                    end
                end
            end
            S_EXE: begin
                alu_op = d_alu;
                if (d_beq || d_bne) begin
                    PCSource = 2'd1; PCWrite = d_beq ? Zero : ~Zero;
                end else if (d_jr || d_jalr) begin
                    PCSource = 2'd3; PCWrite = 1'b1;
                end else if (d_load || d_store) ALUSrcB = 2'd2;
                else if (d_imm) begin
                    ALUSrcB = 2'd2; EXTOp = ~d_zext;
                end else if (d_shamt) AregSel = 1'b1;
            end
            S_MEM: begin
                IorD = 1'b1; MemRead = d_load;
                MemWrite = d_store & ~timeout;
            end
            S_WB: begin
                RegWrite = 1'b1;
                GPRSel = d_rtype ? 2'd0 : 2'd1;
                WDSel = d_load ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
`ifdef SUBWORD_EN
        if (state_q == S_MEM || state_q == S_WB) begin
            MemSize = d_size; LdUnsigned = d_uns;
        end
`else
        MemSize = 2'd0; LdUnsigned = 1'b0;
`endif
        if (rst) begin
            RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
        end
    end

    assign ALUOp        = ALUOP_W'(alu_op);
    assign State        = state_q;
    assign IllegalInstr = illegal_q;
    assign BusErr       = bus_err_q;
endmodule

// File: tb/tb_mc_ctrl_p.sv
// Bench for mc_ctrl_p: per-cycle output vectors against an instruction-level
// model; two instances (timeout 16 / ALUOp width 4, timeout 4 / width 6).
module tb_mc_ctrl_p;
`ifdef SUBWORD_EN
    localparam bit SUBEN = 1'b1;
`else
    localparam bit SUBEN = 1'b0;
`endif
    localparam int K_R = 0, K_SH = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_JALR = 10;
    localparam int K_ILL = 11;
    localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;
    localparam int P_TRAP = 5;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] alu;
        bit         zext;
        logic [1:0] size;
        bit         uns;
        bit         sub;
    } ins_t;

    typedef struct packed {
        logic [1:0] aluhi;
        logic ill, berr;
        logic [2:0] st;
        logic pcw, irw, rw, mw, mr, ext, srca, asel;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic [1:0] pcs, gpr, wds;
        logic iord;
        logic [1:0] msz;
        logic uns;
    } ov_t;

    logic clk = 1'b0;
    logic rst, Zero, MemReady;
    logic [5:0] Op, Funct;
    logic RegWrite, MemWrite, MemRead, PCWrite, IRWrite, EXTOp, ALUSrcA;
    logic AregSel, IorD, LdUnsigned, IllegalInstr, BusErr;
    logic [1:0] ALUSrcB, PCSource, GPRSel, WDSel, MemSize;
    logic [3:0] ALUOp;
    logic [2:0] State;
    logic RegWrite_t, MemWrite_t, MemRead_t, PCWrite_t, IRWrite_t, EXTOp_t;
    logic ALUSrcA_t, AregSel_t, IorD_t, LdUnsigned_t, IllegalInstr_t, BusErr_t;
    logic [1:0] ALUSrcB_t, PCSource_t, GPRSel_t, WDSel_t, MemSize_t;
    logic [5:0] ALUOp_t;
    logic [2:0] State_t;
    ov_t a1, a2;
    int checks = 0;
    int failures = 0;
    ins_t tab[$];

    always #5 clk = ~clk;

    mc_ctrl_p u_dut (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
        .MemReady(MemReady), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .AregSel(AregSel),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .GPRSel(GPRSel), .WDSel(WDSel), .IorD(IorD), .MemSize(MemSize),
        .LdUnsigned(LdUnsigned), .IllegalInstr(IllegalInstr),
        .BusErr(BusErr), .State(State)
    );

    mc_ctrl_p #(.ALUOP_W(6), .MEM_TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
        .MemReady(MemReady), .RegWrite(RegWrite_t), .MemWrite(MemWrite_t),
        .MemRead(MemRead_t), .PCWrite(PCWrite_t), .IRWrite(IRWrite_t),
        .EXTOp(EXTOp_t), .ALUSrcA(ALUSrcA_t), .AregSel(AregSel_t),
        .ALUSrcB(ALUSrcB_t), .ALUOp(ALUOp_t), .PCSource(PCSource_t),
        .GPRSel(GPRSel_t), .WDSel(WDSel_t), .IorD(IorD_t),
        .MemSize(MemSize_t), .LdUnsigned(LdUnsigned_t),
        .IllegalInstr(IllegalInstr_t), .BusErr(BusErr_t), .State(State_t)
    );

    assign a1 = {2'b00, IllegalInstr, BusErr, State, PCWrite, IRWrite,
                 RegWrite, MemWrite, MemRead, EXTOp, ALUSrcA, AregSel,
                 ALUSrcB, ALUOp, PCSource, GPRSel, WDSel, IorD, MemSize,
                 LdUnsigned};
    assign a2 = {ALUOp_t[5:4], IllegalInstr_t, BusErr_t, State_t,
                 PCWrite_t, IRWrite_t, RegWrite_t, MemWrite_t, MemRead_t,
                 EXTOp_t, ALUSrcA_t, AregSel_t, ALUSrcB_t, ALUOp_t[3:0],
                 PCSource_t, GPRSel_t, WDSel_t, IorD_t, MemSize_t,
                 LdUnsigned_t};

    function automatic void add(input logic [5:0] op, input logic [5:0] fn,
                                input int kind, input logic [3:0] alu,
                                input bit zx, input logic [1:0] sz,
                                input bit un, input bit sb);
        tab.push_back('{op, fn, kind, alu, zx, sz, un, sb});
    endfunction

    task automatic build_table();
        add(6'h00, 6'h20, K_R, 4'd1, 0, 0, 0, 0);
        add(6'h00, 6'h21, K_R, 4'd1, 0, 0, 0, 0);
        add(6'h00, 6'h22, K_R, 4'd2, 0, 0, 0, 0);
        add(6'h00, 6'h23, K_R, 4'd2, 0, 0, 0, 0);
        add(6'h00, 6'h24, K_R, 4'd3, 0, 0, 0, 0);
        add(6'h00, 6'h25, K_R, 4'd4, 0, 0, 0, 0);
        add(6'h00, 6'h26, K_R, 4'd11, 0, 0, 0, 0);
        add(6'h00, 6'h27, K_R, 4'd9, 0, 0, 0, 0);
        add(6'h00, 6'h2A, K_R, 4'd5, 0, 0, 0, 0);
        add(6'h00, 6'h2B, K_R, 4'd6, 0, 0, 0, 0);
        add(6'h00, 6'h04, K_R, 4'd7, 0, 0, 0, 0);
        add(6'h00, 6'h06, K_R, 4'd8, 0, 0, 0, 0);
        add(6'h00, 6'h07, K_R, 4'd12, 0, 0, 0, 0);
        add(6'h00, 6'h00, K_SH, 4'd7, 0, 0, 0, 0);
        add(6'h00, 6'h02, K_SH, 4'd8, 0, 0, 0, 0);
        add(6'h00, 6'h03, K_SH, 4'd12, 0, 0, 0, 0);
        add(6'h00, 6'h08, K_JR, 4'd1, 0, 0, 0, 0);
        add(6'h00, 6'h09, K_JALR, 4'd1, 0, 0, 0, 0);
        add(6'h08, 6'h00, K_I, 4'd1, 0, 0, 0, 0);
        add(6'h0A, 6'h00, K_I, 4'd5, 0, 0, 0, 0);
        add(6'h0C, 6'h00, K_I, 4'd3, 1, 0, 0, 0);
        add(6'h0D, 6'h00, K_I, 4'd4, 1, 0, 0, 0);
        add(6'h0F, 6'h00, K_I, 4'd10, 0, 0, 0, 0);
        add(6'h23, 6'h00, K_LD, 4'd1, 0, 0, 0, 0);
        add(6'h2B, 6'h00, K_ST, 4'd1, 0, 0, 0, 0);
        add(6'h04, 6'h00, K_BEQ, 4'd2, 0, 0, 0, 0);
        add(6'h05, 6'h00, K_BNE, 4'd2, 0, 0, 0, 0);
        add(6'h02, 6'h00, K_J, 4'd1, 0, 0, 0, 0);
        add(6'h03, 6'h00, K_JAL, 4'd1, 0, 0, 0, 0);
        add(6'h20, 6'h00, K_LD, 4'd1, 0, 2, 0, 1);
        add(6'h24, 6'h00, K_LD, 4'd1, 0, 2, 1, 1);
        add(6'h21, 6'h00, K_LD, 4'd1, 0, 1, 0, 1);
        add(6'h25, 6'h00, K_LD, 4'd1, 0, 1, 1, 1);
        add(6'h28, 6'h00, K_ST, 4'd1, 0, 2, 0, 1);
        add(6'h29, 6'h00, K_ST, 4'd1, 0, 1, 0, 1);
    endtask

    function automatic ins_t lookup(input logic [5:0] op, input logic [5:0] fn);
        ins_t r;
        r = '{op, fn, K_ILL, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0};
        foreach (tab[j])
            if (tab[j].op == op && (op != 6'h00 || tab[j].fn == fn)) r = tab[j];
        return r;
    endfunction

    // expected outputs for one cycle of an instruction, from its class
    function automatic ov_t exp_out(input ins_t i, input int ph, input bit lg,
                                    input bit rdy, input bit z, input bit tmo,
                                    input bit ill, input bit berr);
        ov_t o;
        o = '0; o.ext = 1; o.srca = 1; o.alu = 4'd1;
        o.ill = ill; o.berr = berr; o.st = 3'(ph);
        case (ph)
            P_IF: begin
                o.mr = 1; o.srca = 0; o.srcb = 2'd1; o.pcw = rdy; o.irw = rdy;
            end
            P_ID: if (lg) begin
                case (i.kind)
                    K_J: begin o.pcw = 1; o.pcs = 2'd2; end
                    K_JAL: begin
                        o.pcw = 1; o.pcs = 2'd2; o.rw = 1;
                        o.gpr = 2'd2; o.wds = 2'd2;
                    end
                    K_JALR: begin o.rw = 1; o.wds = 2'd2; end
                    K_JR: ;
                    default: begin o.srca = 0; o.srcb = 2'd3; end
                endcase
            end
            P_EXE: begin
                o.alu = i.alu;
                case (i.kind)
                    K_BEQ: begin o.pcs = 2'd1; o.pcw = z; end
                    K_BNE: begin o.pcs = 2'd1; o.pcw = !z; end
                    K_JR, K_JALR: begin o.pcs = 2'd3; o.pcw = 1; end
                    K_LD, K_ST: o.srcb = 2'd2;
                    K_I: begin o.srcb = 2'd2; o.ext = !i.zext; end
                    K_SH: o.asel = 1;
                    default: ;
                endcase
            end
            P_MEM: begin
                o.iord = 1; o.msz = i.size; o.uns = i.uns;
                o.mr = (i.kind == K_LD); o.mw = (i.kind == K_ST) && !tmo;
            end
            P_WB: begin
                o.rw = 1; o.msz = i.size; o.uns = i.uns;
                o.gpr = (i.kind == K_R || i.kind == K_SH) ? 2'd0 : 2'd1;
                o.wds = (i.kind == K_LD) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        return o;
    endfunction

    // one instruction: model builds the cycle schedule, then each cycle is checked
    task automatic test_instr(input string tag, input ins_t i, input bit z,
                              input int wif, input int wmem, input int to,
                              input bit [1:0] chk, input int ntrap,
                              output bit trapped);
        int qph[$];
        bit qrdy[$], qtmo[$], qill[$], qberr[$];
        bit lg, ill, berr, dead, rdy, tmo;
        ov_t e;
        lg = (i.kind != K_ILL) && (!i.sub || SUBEN);
        ill = 0; berr = 0; dead = 0;
        for (int k = 0; k <= wif; k++) begin
            rdy = (k == wif); tmo = !rdy && (k == to - 1);
            qph.push_back(P_IF); qrdy.push_back(rdy); qtmo.push_back(tmo);
            qill.push_back(ill); qberr.push_back(berr);
            if (tmo) begin dead = 1; berr = 1; break; end
        end
        if (!dead) begin
            qph.push_back(P_ID); qrdy.push_back(0); qtmo.push_back(0);
            qill.push_back(ill); qberr.push_back(berr);
            if (!lg) begin dead = 1; ill = 1; end
        end
        if (!dead && i.kind != K_J && i.kind != K_JAL) begin
            qph.push_back(P_EXE); qrdy.push_back(0); qtmo.push_back(0);
            qill.push_back(ill); qberr.push_back(berr);
        end
        if (!dead && (i.kind == K_LD || i.kind == K_ST))
            for (int k = 0; k <= wmem; k++) begin
                rdy = (k == wmem); tmo = !rdy && (k == to - 1);
                qph.push_back(P_MEM); qrdy.push_back(rdy); qtmo.push_back(tmo);
                qill.push_back(ill); qberr.push_back(berr);
                if (tmo) begin dead = 1; berr = 1; break; end
            end
        if (!dead && (i.kind == K_R || i.kind == K_SH || i.kind == K_I ||
                      i.kind == K_LD)) begin
            qph.push_back(P_WB); qrdy.push_back(0); qtmo.push_back(0);
            qill.push_back(ill); qberr.push_back(berr);
        end
        if (dead)
            repeat (ntrap) begin
                qph.push_back(P_TRAP); qrdy.push_back(0); qtmo.push_back(0);
                qill.push_back(ill); qberr.push_back(berr);
            end
        trapped = dead;
        Op = i.op; Funct = i.fn; Zero = z;
        foreach (qph[n]) begin
            if (qph[n] == P_IF || qph[n] == P_MEM) MemReady = qrdy[n];
            else MemReady = 1'($urandom);
            @(negedge clk);
            e = exp_out(i, qph[n], lg, qrdy[n], z, qtmo[n], qill[n], qberr[n]);
            if (chk[0]) begin
                checks++;
                if (a1 !== e) begin
                    failures++;
                    $display("FAIL %s cyc=%0d dut16 got=%h exp=%h", tag, n, a1, e);
                end
            end
            if (chk[1]) begin
                checks++;
                if (a2 !== e) begin
                    failures++;
                    $display("FAIL %s cyc=%0d dut4 got=%h exp=%h", tag, n, a2, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        ov_t e;
        rst = 1'b1; MemReady = 1'b1; Zero = 1'($urandom);
        Op = 6'($urandom); Funct = 6'($urandom);
        @(negedge clk);
        e = exp_out(tab[0], P_IF, 1, 0, 0, 0, 0, 0);
        checks++;
        if (a1 !== e) begin
            failures++; $display("FAIL reset dut16 got=%h exp=%h", a1, e);
        end
        checks++;
        if (a2 !== e) begin
            failures++; $display("FAIL reset dut4 got=%h exp=%h", a2, e);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_alu_and_branch();
        bit tr;
        test_reset();
        test_instr("add", lookup(6'h00, 6'h20), 0, 0, 0, 4, 2'b11, 2, tr);
        test_instr("beq_z1", lookup(6'h04, 6'h00), 1, 0, 0, 4, 2'b11, 2, tr);
        test_instr("bne_z1", lookup(6'h05, 6'h00), 1, 0, 0, 4, 2'b11, 2, tr);
        test_instr("bne_z0", lookup(6'h05, 6'h00), 0, 1, 0, 4, 2'b11, 2, tr);
        test_instr("jal", lookup(6'h03, 6'h00), 0, 0, 0, 4, 2'b11, 2, tr);
        test_instr("sra", lookup(6'h00, 6'h03), 0, 0, 0, 4, 2'b11, 2, tr);
        test_instr("ori", lookup(6'h0D, 6'h00), 0, 0, 0, 4, 2'b11, 2, tr);
    endtask

    task automatic test_lw_wait();
        bit tr;
        test_reset();
        test_instr("lw_wait3", lookup(6'h23, 6'h00), 0, 0, 3, 4, 2'b11, 2, tr);
        test_instr("sw_wait3", lookup(6'h2B, 6'h00), 0, 3, 3, 4, 2'b11, 2, tr);
    endtask

    task automatic test_illegal();
        bit tr;
        test_reset();
        test_instr("illegal", lookup(6'h3F, 6'h00), 0, 0, 0, 4, 2'b11, 20, tr);
        checks++;
        if (tr !== 1'b1) begin
            failures++; $display("FAIL illegal_trapped got=%0b exp=1", tr);
        end
        test_reset();
        test_instr("bad_funct", lookup(6'h00, 6'h3F), 0, 0, 0, 4, 2'b11, 3, tr);
        test_reset();
    endtask

    task automatic test_timeout();
        bit tr;
        test_reset();
        test_instr("if_to4", lookup(6'h00, 6'h20), 0, 10, 0, 4, 2'b10, 4, tr);
        test_reset();
        test_instr("mem_to4", lookup(6'h2B, 6'h00), 0, 0, 10, 4, 2'b10, 3, tr);
        test_reset();
        test_instr("if_to16", lookup(6'h23, 6'h00), 0, 20, 0, 16, 2'b01, 3, tr);
        test_reset();
    endtask

    task automatic test_subword();
        bit tr;
        test_reset();
        test_instr("sb", lookup(6'h28, 6'h00), 0, 0, 0, 4, 2'b11, 3, tr);
        if (tr) test_reset();
        test_instr("lbu", lookup(6'h24, 6'h00), 0, 0, 1, 4, 2'b11, 3, tr);
        if (tr) test_reset();
        test_instr("lh", lookup(6'h21, 6'h00), 0, 1, 0, 4, 2'b11, 3, tr);
        if (tr) test_reset();
    endtask

    task automatic test_mid_reset();
        ov_t e;
        test_reset();
        Op = 6'h2B; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        MemReady = 1'b0;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1 || State !== 3'd3) begin
            failures++;
            $display("FAIL mid_pre got=%0b/%0d exp=1/3", MemWrite, State);
        end
        #2 rst = 1'b1; MemReady = 1'b1;
        #1 e = exp_out(tab[0], P_IF, 1, 0, 0, 0, 0, 0);
        checks++;
        if (a1 !== e) begin
            failures++; $display("FAIL mid_reset dut16 got=%h exp=%h", a1, e);
        end
        checks++;
        if (a2 !== e) begin
            failures++; $display("FAIL mid_reset dut4 got=%h exp=%h", a2, e);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_random();
        bit tr;
        ins_t i;
        test_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8)
                i = tab[$urandom_range(0, tab.size() - 1)];
            else
                i = lookup(6'($urandom), 6'($urandom));
            test_instr("random", i, 1'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 3), 4, 2'b11, 2, tr);
            if (tr) test_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; Zero = 1'b0; Op = '0; Funct = '0; MemReady = 1'b0;
        build_table();
        test_reset();
        test_alu_and_branch();
        test_lw_wait();
        test_illegal();
        test_timeout();
        test_subword();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
